// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage and the opcode decoder:
// datapath widths, opcode field position, opcode values and the fetch FSM states.
package instr_fetch_unit_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  // Opcode field inside an instruction word
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;

  // Opcode values understood by the decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  // Instructions are word aligned: clear the byte offset of an address
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
// master: the fetch unit. slave: instruction memory / decode / execute side.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  // Instruction memory read channel
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  // Decode handshake
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_word;
  logic [5:0]         instr_op;
  logic [ADDR_W-1:0]  instr_pc;

  // Redirect from execute
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_word, instr_op, instr_pc,
    input  imem_rvalid, imem_rdata, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_word, instr_op, instr_pc,
    output imem_rvalid, imem_rdata, instr_ready, branch_taken, branch_target
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one outstanding read at a time
// to variable-latency instruction memory, hands each word to decode with a
// valid/ready handshake, and redirects on taken branches while squashing any
// wrong-path word that is in flight or being held.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_fetch_unit_if.master         bus,
  output logic [31:0]                fetch_count
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  // Set when a redirect happens while a read is outstanding; the response
  // that eventually returns belongs to the old path and must be dropped.
  logic              squash;
  logic [ADDR_W-1:0] branch_pc;

  assign branch_pc = align_word(bus.branch_target);

  // Fetch FSM with PC, squash flag, registered memory/decode outputs and handshake counter
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch;
    // all state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state           <= S_IDLE;
      pc              <= RESET_PC;
      squash          <= 1'b0;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= RESET_PC;
      bus.instr_valid <= 1'b0;
      bus.instr_word  <= '0;
      bus.instr_op    <= '0;
      bus.instr_pc    <= '0;
      fetch_count     <= '0;
    end else begin
      // The request strobe is a single-cycle pulse raised only on entry to FETCH
      bus.imem_req <= 1'b0;

      case (state)
        S_IDLE: begin
          state        <= S_FETCH;
          bus.imem_req <= 1'b1;
          if (bus.branch_taken) begin
            pc            <= branch_pc;
            bus.imem_addr <= branch_pc;
          end else begin
            bus.imem_addr <= pc;
          end
        end

        S_FETCH: begin
          // The request already went out at the old PC; its reply is wrong-path
          state <= S_WAIT;
          if (bus.branch_taken) begin
            pc     <= branch_pc;
            squash <= 1'b1;
          end
        end

        S_WAIT: begin
          if (bus.branch_taken) begin
            pc <= branch_pc;
            if (bus.imem_rvalid) begin
              // Reply arrives together with the redirect: drop it and refetch
              squash        <= 1'b0;
              state         <= S_FETCH;
              bus.imem_req  <= 1'b1;
              bus.imem_addr <= branch_pc;
            end else begin
              squash <= 1'b1;
            end
          end else if (bus.imem_rvalid) begin
            if (squash) begin
              squash        <= 1'b0;
              state         <= S_FETCH;
              bus.imem_req  <= 1'b1;
              bus.imem_addr <= pc;
            end else begin
              bus.instr_word  <= bus.imem_rdata;
              bus.instr_op    <= bus.imem_rdata[OP_HI:OP_LO];
              bus.instr_pc    <= pc;
              bus.instr_valid <= 1'b1;
              pc              <= pc + ADDR_W'(4);
              state           <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          // A handshake counts even when a redirect kills the next fetch
          if (bus.instr_ready) begin
            fetch_count <= fetch_count + 32'd1;
          end
          if (bus.branch_taken) begin
            pc              <= branch_pc;
            bus.instr_valid <= 1'b0;
            state           <= S_FETCH;
            bus.imem_req    <= 1'b1;
            bus.imem_addr   <= branch_pc;
          end else if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            state           <= S_FETCH;
            bus.imem_req    <= 1'b1;
            bus.imem_addr   <= pc;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
